// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key-matrix event encoder.
package key_evt_pkg;
    localparam int NUM_KEYS  = 36;
    localparam int KEY_IDX_W = 6;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] key;
        logic                 on;
    } key_evt_t;

    function automatic logic [KEY_IDX_W-1:0] popcount(input logic [NUM_KEYS-1:0] v);
        logic [KEY_IDX_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            cnt = cnt + {{(KEY_IDX_W-1){1'b0}}, v[i]};
        return cnt;
    endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// First-word fall-through FIFO of key events; push is ignored while full.
module key_evt_fifo
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push,
    input  key_evt_t i_data,
    input  logic     i_pop,
    output key_evt_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int AW = $clog2(DEPTH);

    key_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    // Head reads as zero when empty so the outputs have a defined reset value.
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/key_event_encoder.sv
// Scans the registered key map one pad per cycle and queues note-on/off events
// whenever a pad's level differs from what was last reported.
module key_event_encoder
    import key_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_KEYS-1:0]  i_keys,
    output logic                 o_evt_valid,
    input  logic                 i_evt_ready,
    output logic [KEY_IDX_W-1:0] o_evt_key,
    output logic                 o_evt_on,
    output logic [KEY_IDX_W-1:0] o_held_count
);
    logic [NUM_KEYS-1:0]  keys_q;
    logic [NUM_KEYS-1:0]  reported;
    logic [KEY_IDX_W-1:0] ptr;
    logic [KEY_IDX_W-1:0] ptr_nxt;
    logic [KEY_IDX_W-1:0] held_q;
    logic                 mismatch;
    logic                 push;
    logic                 advance;
    logic                 fifo_full;
    logic                 fifo_empty;
    key_evt_t             push_evt;
    key_evt_t             head;

    assign mismatch = keys_q[ptr] ^ reported[ptr];
    assign push     = mismatch && !fifo_full;
    // A pending change holds the scanner on its key so no transition is dropped.
    assign advance  = !mismatch || !fifo_full;
    assign ptr_nxt  = (ptr == KEY_IDX_W'(NUM_KEYS-1)) ? '0 : ptr + 1'b1;
    assign push_evt = '{key: ptr, on: keys_q[ptr]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            keys_q   <= '0;
            reported <= '0;
            ptr      <= '0;
            held_q   <= '0;
        end else begin
            keys_q <= i_keys;
            if (push)
                reported[ptr] <= keys_q[ptr];
            if (advance)
                ptr <= ptr_nxt;
            held_q <= popcount(reported);
        end
    end

    key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_evt),
        .i_pop   (i_evt_ready),
        .o_data  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_evt_valid  = !fifo_empty;
    assign o_evt_key    = head.key;
    assign o_evt_on     = head.on;
    assign o_held_count = held_q;
endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench: directed scenarios plus randomized toggling checked
// against an event-level model of the reported key map.
module tb_key_event_encoder;
    import key_evt_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_KEYS-1:0]  keys = '0;
    logic                 ready = 1'b0;
    logic                 evt_valid;
    logic [KEY_IDX_W-1:0] evt_key;
    logic                 evt_on;
    logic [KEY_IDX_W-1:0] held;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int evk[$];
    bit evo[$];

    always #5 clk = ~clk;

    key_event_encoder #(.FIFO_DEPTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_keys       (keys),
        .o_evt_valid  (evt_valid),
        .i_evt_ready  (ready),
        .o_evt_key    (evt_key),
        .o_evt_on     (evt_on),
        .o_held_count (held)
    );

    // Cycles since reset; equals the scan pointer while the FIFO never fills.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Record handshakes just before the edge that completes them.
    always begin
        @(negedge clk);
        #4;
        if (!rst && evt_valid && ready) begin
            evk.push_back(int'(evt_key));
            evo.push_back(evt_on);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        evk.delete();
        evo.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic wait_ptr(input int p);
        for (int i = 0; i < 40 && (cyc % NUM_KEYS) != p; i++)
            @(negedge clk);
    endtask

    task automatic test_reset();
        int seen;
        keys = '0;
        ready = 1'b1;
        do_reset();
        n_assert += 4;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        if (evt_key !== '0)     begin n_fail++; $display("FAIL reset_key: got %0d want 0", evt_key); end
        if (evt_on !== 1'b0)    begin n_fail++; $display("FAIL reset_on: got %b want 0", evt_on); end
        if (held !== '0)        begin n_fail++; $display("FAIL reset_held: got %0d want 0", held); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (evt_valid !== 1'b0) seen++;
        end
        n_assert += 2;
        if (seen != 0)   begin n_fail++; $display("FAIL idle_valid: got %0d valid cycles want 0", seen); end
        if (held !== '0) begin n_fail++; $display("FAIL idle_held: got %0d want 0", held); end
    endtask

    task automatic test_single();
        do_reset();
        while (cyc < 10) tick(1);
        keys[7] = 1'b1;
        tick(50);
        n_assert += 4;
        if (evk.size() != 1) begin n_fail++; $display("FAIL single_on_cnt: got %0d want 1", evk.size()); end
        if ((evk.size() > 0 ? evk[0] : -1) != 7) begin n_fail++; $display("FAIL single_on_key: got %0d want 7", evk.size() > 0 ? evk[0] : -1); end
        if ((evo.size() > 0 ? int'(evo[0]) : -1) != 1) begin n_fail++; $display("FAIL single_on_flag: want 1"); end
        if (held !== 6'd1) begin n_fail++; $display("FAIL single_on_held: got %0d want 1", held); end
        clear_q();
        keys[7] = 1'b0;
        tick(50);
        n_assert += 4;
        if (evk.size() != 1) begin n_fail++; $display("FAIL single_off_cnt: got %0d want 1", evk.size()); end
        if ((evk.size() > 0 ? evk[0] : -1) != 7) begin n_fail++; $display("FAIL single_off_key: got %0d want 7", evk.size() > 0 ? evk[0] : -1); end
        if ((evo.size() > 0 ? int'(evo[0]) : -1) != 0) begin n_fail++; $display("FAIL single_off_flag: want 0"); end
        if (held !== 6'd0) begin n_fail++; $display("FAIL single_off_held: got %0d want 0", held); end
    endtask

    task automatic test_multi();
        int exp_k[3] = '{3, 20, 35};
        clear_q();
        wait_ptr(NUM_KEYS - 1);
        keys = '0;
        keys[3] = 1'b1; keys[20] = 1'b1; keys[35] = 1'b1;
        tick(50);
        n_assert += 2;
        if (evk.size() != 3) begin n_fail++; $display("FAIL multi_cnt: got %0d want 3", evk.size()); end
        if (held !== 6'd3)   begin n_fail++; $display("FAIL multi_held: got %0d want 3", held); end
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (i >= evk.size() || evk[i] != exp_k[i] || evo[i] != 1'b1) begin
                n_fail++;
                $display("FAIL multi_evt%0d: got key %0d want key %0d on", i, i < evk.size() ? evk[i] : -1, exp_k[i]);
            end
        end
    endtask

    task automatic test_pulse();
        clear_q();
        wait_ptr(20);
        keys[5] = 1'b1;
        tick(1);
        keys[5] = 1'b0;
        tick(80);
        n_assert += 2;
        if (evk.size() != 0) begin n_fail++; $display("FAIL pulse_cnt: got %0d events want 0", evk.size()); end
        if (held !== 6'd3)   begin n_fail++; $display("FAIL pulse_held: got %0d want 3", held); end
    endtask

    task automatic test_back_to_back();
        int exp_k[12] = '{1, 4, 6, 9, 11, 14, 17, 22, 25, 28, 31, 33};
        int moved;
        keys = '0;
        ready = 1'b0;
        do_reset();
        wait_ptr(NUM_KEYS - 1);
        foreach (exp_k[i]) keys[exp_k[i]] = 1'b1;
        tick(80);
        n_assert += 4;
        if (held !== 6'd8)       begin n_fail++; $display("FAIL stall_held: got %0d want 8", held); end
        if (evt_valid !== 1'b1)  begin n_fail++; $display("FAIL stall_valid: got %b want 1", evt_valid); end
        if (evt_key !== 6'd1)    begin n_fail++; $display("FAIL stall_head_key: got %0d want 1", evt_key); end
        if (evt_on !== 1'b1)     begin n_fail++; $display("FAIL stall_head_on: got %b want 1", evt_on); end
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (evt_key !== 6'd1 || evt_on !== 1'b1 || evt_valid !== 1'b1) moved++;
        end
        n_assert++;
        if (moved != 0) begin n_fail++; $display("FAIL stall_head_stable: got %0d changed cycles want 0", moved); end
        ready = 1'b1;
        tick(100);
        n_assert += 3;
        if (evk.size() != 12)   begin n_fail++; $display("FAIL drain_cnt: got %0d want 12", evk.size()); end
        if (held !== 6'd12)     begin n_fail++; $display("FAIL drain_held: got %0d want 12", held); end
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", evt_valid); end
        for (int i = 0; i < 12; i++) begin
            n_assert++;
            if (i >= evk.size() || evk[i] != exp_k[i] || evo[i] != 1'b1) begin
                n_fail++;
                $display("FAIL drain_evt%0d: got key %0d want key %0d on", i, i < evk.size() ? evk[i] : -1, exp_k[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] mask;
        int bad;
        ready = 1'b0;
        keys = '0;
        keys[3:0] = 4'hF;
        tick(60);
        n_assert++;
        if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill_valid: got %b want 1", evt_valid); end
        do_reset();
        n_assert += 2;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_cleared_valid: got %b want 0", evt_valid); end
        if (held !== 6'd0)      begin n_fail++; $display("FAIL mid_cleared_held: got %0d want 0", held); end
        ready = 1'b1;
        tick(80);
        mask = '0;
        bad = 0;
        foreach (evk[i]) begin
            if (evk[i] < 4 && evo[i] == 1'b1) mask[evk[i]] = 1'b1;
            else bad++;
        end
        n_assert += 3;
        if (evk.size() != 4 || bad != 0) begin n_fail++; $display("FAIL mid_evt_cnt: got %0d events (%0d unexpected) want 4", evk.size(), bad); end
        if (mask !== 4'hF)  begin n_fail++; $display("FAIL mid_evt_keys: got mask %h want f", mask); end
        if (held !== 6'd4)  begin n_fail++; $display("FAIL mid_held: got %0d want 4", held); end
    endtask

    task automatic test_random();
        logic [NUM_KEYS-1:0] model;
        int alt_err;
        for (int r = 0; r < 3; r++) begin
            keys = '0;
            ready = 1'b1;
            do_reset();
            model = '0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, NUM_KEYS-1)] ^= 1'b1;
                ready = ($urandom_range(0, 9) < 6);
                tick(1);
            end
            ready = 1'b1;
            tick(150);
            // Each event must flip the consumer's view of its key.
            alt_err = 0;
            foreach (evk[i]) begin
                if (evk[i] >= NUM_KEYS || evo[i] == model[evk[i]]) alt_err++;
                else model[evk[i]] = evo[i];
            end
            n_assert += 4;
            if (alt_err != 0)   begin n_fail++; $display("FAIL rnd%0d_alternate: got %0d bad events want 0", r, alt_err); end
            if (model !== keys) begin n_fail++; $display("FAIL rnd%0d_final_map: got %h want %h", r, model, keys); end
            if (held !== KEY_IDX_W'($countones(keys))) begin n_fail++; $display("FAIL rnd%0d_held: got %0d want %0d", r, held, $countones(keys)); end
            if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_drained: got %b want 0", r, evt_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_pulse();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
